// File: rtl/mem_pattern_writer.sv
// Avalon-MM DMA writer: fills a buffer with an incrementing or Galois-LFSR
// 64-bit pattern and keeps the reader-compatible checksum sum(hi+lo) mod 2^32.
module mem_pattern_writer (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  ctrl_address,
    input  logic        ctrl_write,
    input  logic [31:0] ctrl_writedata,
    input  logic        ctrl_read,
    output logic [31:0] ctrl_readdata,
    output logic        ctrl_waitrequest,
    output logic        master_write,
    output logic [31:0] master_address,
    output logic [63:0] master_writedata,
    input  logic        master_waitrequest,
    output logic        master_burstcount,
    output logic [7:0]  master_byteenable,
    output logic        irq
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_WRITE = 2'd1;
    localparam logic [1:0]  ST_DONE  = 2'd2;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    logic [1:0]  state;
    logic [31:0] start_addr;
    logic [31:0] remaining;
    logic [31:0] seed;
    logic [31:0] checksum;
    logic [31:0] pat;         // S(2k+2): first half of the word after the one presented
    logic        mode;
    logic        aborted;
    logic        abort_pend;

    function automatic logic [31:0] pat_step(input logic [31:0] s, input logic lfsr);
        if (lfsr)
            return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
        return s + 32'd1;
    endfunction

    logic        busy, done;
    logic        wr_addr0, wr_addr1, wr_addr2, wr_addr3;
    logic        start, start_run, start_empty;
    logic        abort_req, irq_clr, accept, last_beat, irq_set;
    logic [31:0] seed_eff, s1, s2, p1, p2;
    logic [31:0] rd_mux;

    assign busy        = (state == ST_WRITE);
    assign done        = (state == ST_DONE);
    assign wr_addr0    = ctrl_write && (ctrl_address == 2'd0);
    assign wr_addr1    = ctrl_write && (ctrl_address == 2'd1);
    assign wr_addr2    = ctrl_write && (ctrl_address == 2'd2);
    assign wr_addr3    = ctrl_write && (ctrl_address == 2'd3);
    assign start       = wr_addr1 && !busy;
    assign start_run   = start && (ctrl_writedata != 32'd0);
    assign start_empty = start && (ctrl_writedata == 32'd0);
    assign abort_req   = wr_addr3 && ctrl_writedata[1];
    assign irq_clr     = wr_addr3 && ctrl_writedata[2];
    assign accept      = busy && master_write && !master_waitrequest;
    assign last_beat   = accept && ((remaining == 32'd1) || abort_pend || abort_req);
    assign irq_set     = start_empty || last_beat;

    // The LFSR has a lock-up state at zero, so a zero seed is promoted to 1.
    assign seed_eff = (mode && (seed == 32'd0)) ? 32'd1 : seed;
    assign s1       = pat_step(seed_eff, mode);
    assign s2       = pat_step(s1, mode);
    assign p1       = pat_step(pat, mode);
    assign p2       = pat_step(p1, mode);

    always_comb begin
        rd_mux = 32'd0;
        case (ctrl_address)
            2'd0: rd_mux = start_addr;
            2'd1: rd_mux = remaining;
            2'd2: rd_mux = checksum;
            2'd3: rd_mux = {28'd0, aborted, mode, done, busy};
            default: rd_mux = 32'd0;
        endcase
    end

    assign master_burstcount = 1'b1;
    assign master_byteenable = 8'hFF;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            start_addr       <= 32'd0;
            remaining        <= 32'd0;
            seed             <= 32'd0;
            checksum         <= 32'd0;
            pat              <= 32'd0;
            mode             <= 1'b0;
            aborted          <= 1'b0;
            abort_pend       <= 1'b0;
            irq              <= 1'b0;
            master_write     <= 1'b0;
            master_address   <= 32'd0;
            master_writedata <= 64'd0;
            ctrl_readdata    <= 32'd0;
            ctrl_waitrequest <= 1'b0;
        end else begin
            ctrl_waitrequest <= 1'b0;
            if (ctrl_read)
                ctrl_readdata <= rd_mux;

            if (wr_addr0 && !busy) start_addr <= {ctrl_writedata[31:3], 3'b000};
            if (wr_addr2 && !busy) seed       <= ctrl_writedata;
            if (wr_addr3 && !busy) mode       <= ctrl_writedata[0];

            // A set in the same cycle as IRQ_CLR wins.
            if (irq_set)
                irq <= 1'b1;
            else if (irq_clr || start_run)
                irq <= 1'b0;

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_run) begin
                        state            <= ST_WRITE;
                        remaining        <= ctrl_writedata;
                        master_address   <= start_addr;
                        master_writedata <= {s1, seed_eff};
                        pat              <= s2;
                        master_write     <= 1'b1;
                        checksum         <= 32'd0;
                        aborted          <= 1'b0;
                        abort_pend       <= 1'b0;
                    end else if (start_empty) begin
                        state      <= ST_DONE;
                        remaining  <= 32'd0;
                        checksum   <= 32'd0;
                        aborted    <= 1'b0;
                        abort_pend <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (abort_req)
                        abort_pend <= 1'b1;
                    // The presented beat is held under stall; it always counts once accepted.
                    if (accept) begin
                        checksum         <= checksum + master_writedata[63:32] + master_writedata[31:0];
                        remaining        <= remaining - 32'd1;
                        master_address   <= master_address + 32'd8;
                        master_writedata <= {p1, pat};
                        pat              <= p2;
                    end
                    if (last_beat) begin
                        state        <= ST_DONE;
                        master_write <= 1'b0;
                        aborted      <= (remaining != 32'd1);
                        abort_pend   <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    master_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_pattern_writer.md
# mem_pattern_writer

Avalon-MM DMA writer that fills an SDRAM buffer with a deterministic 64-bit test pattern. It sits directly upstream of the summing DMA reader: the HPS programs both blocks with the same buffer, runs this block, then the reader. It compares the reader's accumulator with the expected checksum computed here. The checksum uses the reader's arithmetic: sum of (hi32 + lo32) per word, mod 2^32.

## Interface
Parameters: none. All widths are fixed.

- clk  in  1  clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high
- ctrl_address  in  2  register select
- ctrl_write  in  1  slave write strobe
- ctrl_writedata  in  32  slave write data
- ctrl_read  in  1  slave read strobe
- ctrl_readdata  out  32  registered read data
- ctrl_waitrequest  out  1  constant 0; registered, reset 0
- master_write  out  1  write request
- master_address  out  32  byte address, 8-byte aligned
- master_writedata  out  64  pattern word {hi, lo}
- master_waitrequest  in  1  slave stall
- master_burstcount  out  1  constant 1
- master_byteenable  out  8  constant 8'hFF
- irq  out  1  level interrupt; held until cleared

## Operation
Registers (write / read):
- 0: START_ADDR. Write stores writedata with bits [2:0] forced to 0. Read returns START_ADDR.
- 1: COUNT. Write loads the word count and starts the run. Read returns the remaining words.
- 2: SEED. Write stores the seed. Read returns CHECKSUM.
- 3: CTRL.
  - Write bit0 = MODE (0 incrementing, 1 LFSR); bit1 = ABORT (self-clearing); bit2 = IRQ_CLR (self-clearing).
  - Read returns {28'b0, aborted, MODE, done, busy}.

Writes while busy:
- Writes to regs 0 and 2, and to the MODE bit of reg 3, are ignored while busy. A write to reg 1 while busy is ignored.
- ABORT and IRQ_CLR are honoured at any time.

Pattern sequence S(n):
- S(0) = SEED. In LFSR mode, SEED 0 is replaced by 1.
- Incrementing mode: S(n+1) = S(n)+1 mod 2^32.
- LFSR mode: right-shift Galois, mask 32'h80200003. If S[0]=1, S(n+1) = (S>>1) ^ mask; else S(n+1) = S>>1.
- Word k: lo = S(2k), hi = S(2k+1). master_writedata = {hi, lo}.

State machine IDLE / WRITE / DONE:
- IDLE -> WRITE on a reg-1 write with value N ≠ 0. This also:
  - loads remaining = N and master_address = START_ADDR;
  - sets CHECKSUM = 0 and the pattern state to S(0);
  - clears done, aborted and irq.
- A reg-1 write with N = 0 from IDLE or DONE goes straight to DONE. It sets irq, and CHECKSUM = 0.
- WRITE:
  - master_write = 1.
  - On accept (master_write & ~master_waitrequest): CHECKSUM += hi+lo (mod 2^32), remaining -= 1, master_address += 8 (wraps mod 2^32), pattern advances two steps.
  - Leave for DONE on the accept that takes remaining to 0.
- ABORT in WRITE sets a pending flag. The beat currently presented stays stable until it is accepted (Avalon rule), and it counts. Then go to DONE with aborted = 1, remaining left non-zero.
  - ABORT in the same cycle as an accept: that beat counts, then stop.
  - ABORT in IDLE or DONE: no effect.
- DONE: done = 1, irq = 1. A reg-1 write restarts as from IDLE.
- IRQ_CLR drops irq only; done stays set. An IRQ_CLR in the same cycle that irq is set loses, so irq stays 1.
- Reset (any time, including mid-burst): state IDLE; every register 0; MODE 0; remaining 0.
  - Outputs immediately: master_write 0, master_address 0, master_writedata 0, irq 0, ctrl_readdata 0.

## Timing
- Control slave: zero wait states. ctrl_readdata is valid the cycle after ctrl_read, sampled from the current register value.
- Start: a reg-1 write in cycle t gives master_write=1 in t+1, with address START_ADDR and data word 0.
- Back-to-back: after an accept in cycle c, the next word and address are presented in c+1 with master_write still 1. Peak rate is 1 word/cycle.
- Stall: while master_waitrequest=1, master_write, master_address and master_writedata hold unchanged.
- Completion: after the last accept in cycle c, master_write=0, done=1 and irq=1 in c+1. CHECKSUM is final in c+1.
- N=0 start in t: irq=1 in t+1. master_write never asserts.
- Pattern generation is registered: the next word is precomputed so no combinational path exists from master_waitrequest to master_writedata.

## Test plan
- Incrementing run. START_ADDR 0x1000, MODE 0, SEED 0x10, COUNT 2, waitrequest 0.
  - Beats: 0x1000 with 0x00000011_00000010, then 0x1008 with 0x00000013_00000012.
  - irq 1 cycle after the second accept; CHECKSUM 0x46; status 0x2.
- LFSR run. MODE 1, SEED 0, COUNT 1 -> single word 0x80200003_00000001; CHECKSUM 0x80200004.
- Stall. COUNT 3; waitrequest held 1 for 3 cycles on beat 1 -> address, data and write stable throughout. Beats 0 and 2 go back-to-back; total accepts = 3.
- Abort and restart.
  - COUNT 10; ABORT written during beat 4 under waitrequest -> beat 4 completes, no beat 5.
  - Remaining 5; status 0xA; irq 1.
  - IRQ_CLR -> irq 0, status still 0xA. A new COUNT 1 clears aborted.
- Edge cases.
  - COUNT 0 -> irq next cycle, no master_write.
  - START_ADDR 0xFFFFFFF8, COUNT 2 -> second address is 0x00000000.
  - Reset asserted mid-run -> master_write 0 asynchronously; all reads return 0 after release.
- Cross-check. A 256-word LFSR fill followed by a summing-reader run over the same buffer -> reader accumulator equals CHECKSUM.
